// File: rtl/mem_rx_engine.sv
// Receive engine for the serial memory link: frames start/status/payload responses from the pins
// and assembles payloads into parallel words behind a one-entry valid/ready buffer.
module mem_rx_engine #(
   parameter int                   IO_BITS        = 2,
   parameter int                   PAYLOAD_CYCLES = 8,
   parameter logic [IO_BITS-1:0]   SB_READ_FULL   = IO_BITS'(2'b01),
   parameter logic [IO_BITS-1:0]   SB_READ_HALF   = IO_BITS'(2'b10),
   parameter int                   MAX_PENDING    = 3,
   parameter int                   TIMEOUT_CYCLES = 64,
   localparam int                  DATA_BITS      = IO_BITS * PAYLOAD_CYCLES,
   localparam int                  CW             = $clog2(PAYLOAD_CYCLES) + 1,
   localparam int                  PW             = $clog2(MAX_PENDING + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [IO_BITS-1:0]      rx_pins,
   input  logic                    rx_expect,
   input  logic                    word_ready,
   output logic [PW-1:0]           pending,
   output logic                    rx_active,
   output logic                    rx_started,
   output logic [IO_BITS-1:0]      rx_sbs,
   output logic                    rx_sbs_valid,
   output logic [IO_BITS-1:0]      rx_data,
   output logic                    rx_data_valid,
   output logic [CW-1:0]           rx_counter,
   output logic                    rx_done,
   output logic                    word_valid,
   output logic [DATA_BITS-1:0]    word,
   output logic                    word_half,
   output logic                    rx_timeout,
   output logic                    rx_overrun,
   output logic                    expect_overflow
);

   localparam int              TW       = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [TW-1:0]   TMR_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SBS = 2'd1, ST_DATA = 2'd2} state_t;

   state_t                 state_q;
   logic [IO_BITS-1:0]     in_q;
   logic [CW-1:0]          cnt_q, len_q;
   logic                   half_q;
   logic [DATA_BITS-1:0]   asm_q, asm_d, word_q;
   logic [PW-1:0]          pending_q, pending_d;
   logic [TW-1:0]          tmr_q;
   logic                   ovf_q, ovf_d, word_valid_q, word_half_q, timeout_q, overrun_q;
   logic [CW-1:0]          sbs_len_s;
   logic                   start_s, done_s, commit_s, fire_s, dec_s;

   assign start_s  = (state_q == ST_IDLE) && (pending_q != '0) && in_q[0];
   assign done_s   = ((state_q == ST_SBS) && (sbs_len_s == '0)) ||
                     ((state_q == ST_DATA) && (cnt_q == len_q - CW'(1)));
   assign commit_s = done_s && (state_q == ST_DATA);
   // A start chunk on the pins counts as activity, so it holds the timer at zero.
   assign fire_s   = (TIMEOUT_CYCLES != 0) && (state_q == ST_IDLE) && (pending_q != '0) &&
                     !start_s && (tmr_q == TMR_LAST);
   assign dec_s    = (done_s || fire_s) && (pending_q != '0);

   // Payload length selected by the status chunk
   always_comb begin
      sbs_len_s = '0;
      if (in_q == SB_READ_FULL) begin
         sbs_len_s = CW'(PAYLOAD_CYCLES);
      end else if (in_q == SB_READ_HALF) begin
         sbs_len_s = CW'(PAYLOAD_CYCLES / 2);
      end else begin
         sbs_len_s = '0;
      end
   end

   // Assembly word with the current payload chunk merged in
   always_comb begin
      asm_d = asm_q;
      if (state_q == ST_DATA) begin
         asm_d[int'(cnt_q) * IO_BITS +: IO_BITS] = in_q;
      end else begin
         asm_d = asm_q;
      end
   end

   // Outstanding-response count and sticky overflow flag
   always_comb begin
      pending_d = pending_q;
      ovf_d     = ovf_q;
      if (rx_expect && !dec_s) begin
         if (pending_q == PW'(MAX_PENDING)) begin
            ovf_d = 1'b1;
         end else begin
            pending_d = pending_q + PW'(1);
         end
      end else if (!rx_expect && dec_s) begin
         pending_d = pending_q - PW'(1);
      end else begin
         pending_d = pending_q;
      end
   end

   // Framing FSM: input register, status decode, payload counter and word assembly
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         in_q    <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         half_q  <= 1'b0;
         asm_q   <= '0;
      end else begin
         in_q <= rx_pins;
         case (state_q)
            ST_IDLE: begin
               if (start_s) state_q <= ST_SBS;
            end
            ST_SBS: begin
               len_q   <= sbs_len_s;
               half_q  <= (sbs_len_s != CW'(PAYLOAD_CYCLES));
               cnt_q   <= '0;
               asm_q   <= '0;
               state_q <= (sbs_len_s == '0) ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               asm_q <= asm_d;
               if (done_s) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Pending/timeout bookkeeping and the one-entry output word buffer
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q    <= '0;
         ovf_q        <= 1'b0;
         tmr_q        <= '0;
         timeout_q    <= 1'b0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         word_half_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         timeout_q <= fire_s;
         if ((pending_q == '0) || start_s || fire_s) begin
            tmr_q <= '0;
         end else if (state_q == ST_IDLE) begin
            tmr_q <= tmr_q + TW'(1);
         end
         if (commit_s) begin
            word_q       <= asm_d;
            word_half_q  <= half_q;
            word_valid_q <= 1'b1;
            overrun_q    <= word_valid_q && !word_ready;
         end else begin
            overrun_q <= 1'b0;
            if (word_valid_q && word_ready) word_valid_q <= 1'b0;
         end
      end
   end

   assign pending         = pending_q;
   assign rx_active       = start_s || (state_q != ST_IDLE);
   assign rx_started      = start_s;
   assign rx_sbs_valid    = (state_q == ST_SBS);
   assign rx_sbs          = (state_q == ST_SBS) ? in_q : '0;
   assign rx_data_valid   = (state_q == ST_DATA);
   assign rx_data         = (state_q == ST_DATA) ? in_q : '0;
   assign rx_counter      = cnt_q;
   assign rx_done         = done_s;
   assign word_valid      = word_valid_q;
   assign word            = word_q;
   assign word_half       = word_half_q;
   assign rx_timeout      = timeout_q;
   assign rx_overrun      = overrun_q;
   assign expect_overflow = ovf_q;

endmodule

// File: tb/tb_mem_rx_engine.sv
// Self-checking bench for mem_rx_engine at default parameters; assembled words are checked
// against a scoreboard queue filled when each frame is driven.
module tb_mem_rx_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  rx_pins = 2'b00;
   logic        rx_expect = 1'b0;
   logic        word_ready = 1'b1;
   logic [1:0]  pending;
   logic        rx_active, rx_started, rx_sbs_valid, rx_data_valid, rx_done;
   logic [1:0]  rx_sbs, rx_data;
   logic [3:0]  rx_counter;
   logic        word_valid, word_half, rx_timeout, rx_overrun, expect_overflow;
   logic [15:0] word;

   int checks = 0;
   int errors = 0;

   typedef struct {logic [15:0] w; logic h;} exp_t;
   exp_t exp_q[$];
   logic prev_v = 1'b0;
   logic prev_r = 1'b0;

   mem_rx_engine dut (
      .clk(clk), .reset(reset), .rx_pins(rx_pins), .rx_expect(rx_expect),
      .word_ready(word_ready), .pending(pending), .rx_active(rx_active),
      .rx_started(rx_started), .rx_sbs(rx_sbs), .rx_sbs_valid(rx_sbs_valid),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_counter(rx_counter),
      .rx_done(rx_done), .word_valid(word_valid), .word(word), .word_half(word_half),
      .rx_timeout(rx_timeout), .rx_overrun(rx_overrun), .expect_overflow(expect_overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: a new word is one that appears, replaces an accepted word, or overruns.
   always @(negedge clk) begin
      if (word_valid === 1'b1 && (!prev_v || prev_r || rx_overrun === 1'b1)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL word_unexpected: got word=%h half=%b, none expected", word, word_half);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({word, word_half} !== {e.w, e.h}) begin
               errors++;
               $display("FAIL word_data: got word=%h half=%b expected word=%h half=%b",
                        word, word_half, e.w, e.h);
            end
         end
      end
      prev_v <= (word_valid === 1'b1);
      prev_r <= word_ready;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic [1:0] sb, input logic [15:0] data);
      int   len;
      exp_t e;
      len = (sb == 2'b01) ? 8 : ((sb == 2'b10) ? 4 : 0);
      if (len > 0) begin
         e.w = (len == 8) ? data : {8'h00, data[7:0]};
         e.h = (len == 4);
         exp_q.push_back(e);
      end
      rx_pins = 2'b01;
      step();
      checks++;
      if (rx_started !== 1'b1) begin
         errors++;
         $display("FAIL frame_start: rx_started=%b expected 1", rx_started);
      end
      rx_pins = sb;
      step();
      checks++;
      if ({rx_sbs_valid, rx_sbs} !== {1'b1, sb}) begin
         errors++;
         $display("FAIL frame_sbs: valid/sbs=%b/%b expected 1/%b", rx_sbs_valid, rx_sbs, sb);
      end
      for (int k = 0; k < len; k++) begin
         rx_pins = data[k*2 +: 2];
         step();
         checks++;
         if ({rx_data_valid, rx_data, rx_counter} !== {1'b1, data[k*2 +: 2], 4'(k)}) begin
            errors++;
            $display("FAIL frame_chunk%0d: valid/data/cnt=%b/%b/%0d expected 1/%b/%0d",
                     k, rx_data_valid, rx_data, rx_counter, data[k*2 +: 2], k);
         end
      end
      checks++;
      if ({rx_done, rx_active} !== 2'b11) begin
         errors++;
         $display("FAIL frame_done: done/active=%b%b expected 11", rx_done, rx_active);
      end
      rx_pins = 2'b00;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      checks++;
      if ({pending, rx_active, rx_started, rx_sbs, rx_sbs_valid, rx_data, rx_data_valid,
           rx_counter, rx_done, word_valid, word, word_half, rx_timeout, rx_overrun,
           expect_overflow} !== 36'h0) begin
         errors++;
         $display("FAIL reset_outputs: pending=%0d active=%b wv=%b word=%h ovf=%b expected all 0",
                  pending, rx_active, word_valid, word, expect_overflow);
      end
   endtask

   task automatic test_full_read();
      rx_expect = 1'b1;
      step();
      rx_expect = 1'b0;
      checks++;
      if (pending !== 2'd1) begin
         errors++;
         $display("FAIL full_pending_up: pending=%0d expected 1", pending);
      end
      run_frame(2'b01, 16'hE4E4);
      checks++;
      if (word_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_early_word: word_valid=%b expected 0 on done cycle", word_valid);
      end
      step();
      checks++;
      if ({word_valid, word, word_half, pending} !== {1'b1, 16'hE4E4, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL full_word: wv=%b word=%h half=%b pending=%0d expected 1 e4e4 0 0",
                  word_valid, word, word_half, pending);
      end
   endtask

   task automatic test_half_ack();
      rx_expect = 1'b1;
      step();
      step();
      rx_expect = 1'b0;
      checks++;
      if (pending !== 2'd2) begin
         errors++;
         $display("FAIL half_pending_up: pending=%0d expected 2", pending);
      end
      run_frame(2'b10, 16'h001B);
      run_frame(2'b11, 16'h0000);
      step();
      checks++;
      if ({pending, word_valid} !== {2'd0, 1'b0}) begin
         errors++;
         $display("FAIL half_ack_end: pending=%0d wv=%b expected 0 0", pending, word_valid);
      end
   endtask

   task automatic test_no_pending();
      rx_pins = 2'b01;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({rx_started, rx_active} !== 2'b00) begin
            errors++;
            $display("FAIL nopend_start%0d: started/active=%b%b expected 00", i, rx_started, rx_active);
         end
      end
      rx_pins = 2'b00;
      step();
      step();
   endtask

   task automatic test_timeout();
      int n;
      rx_expect = 1'b1;
      step();
      rx_expect = 1'b0;
      n = 0;
      while (rx_timeout !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (n !== 64 || pending !== 2'd0) begin
         errors++;
         $display("FAIL timeout_when: fired after %0d cycles pending=%0d expected 64 0", n, pending);
      end
      for (int i = 0; i < 70; i++) begin
         step();
         if (rx_timeout !== 1'b0) n = -1;
      end
      checks++;
      if (n === -1) begin
         errors++;
         $display("FAIL timeout_once: rx_timeout pulsed again, expected a single pulse");
      end
   endtask

   task automatic test_overrun();
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      word_ready = 1'b0;
      rx_expect = 1'b1;
      step();
      step();
      rx_expect = 1'b0;
      run_frame(2'b01, a);
      step();
      run_frame(2'b01, b);
      step();
      checks++;
      if ({rx_overrun, word_valid, word} !== {1'b1, 1'b1, b}) begin
         errors++;
         $display("FAIL overrun_pulse: ovr=%b wv=%b word=%h expected 1 1 %h", rx_overrun, word_valid, word, b);
      end
      step();
      checks++;
      if (rx_overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_width: rx_overrun=%b expected 0", rx_overrun);
      end
      word_ready = 1'b1;
      step();
      // Second pair: the buffered word is accepted on the cycle the new one commits.
      word_ready = 1'b0;
      rx_expect = 1'b1;
      step();
      step();
      rx_expect = 1'b0;
      run_frame(2'b01, b ^ 16'h5A5A);
      step();
      run_frame(2'b10, a);
      word_ready = 1'b1;
      step();
      checks++;
      if ({rx_overrun, word_valid, word, word_half} !== {1'b1 ^ 1'b1, 1'b1, 8'h00, a[7:0], 1'b1}) begin
         errors++;
         $display("FAIL accept_commit: ovr=%b wv=%b word=%h half=%b expected 0 1 %h 1",
                  rx_overrun, word_valid, word, word_half, {8'h00, a[7:0]});
      end
      step();
      rx_expect = 1'b1;
      step();
      rx_expect = 1'b0;
      run_frame(2'b00, 16'h0000);
      rx_expect = 1'b1;
      step();
      rx_expect = 1'b0;
      checks++;
      if (pending !== 2'd1) begin
         errors++;
         $display("FAIL expect_on_done: pending=%0d expected 1", pending);
      end
      run_frame(2'b00, 16'h0000);
      step();
      checks++;
      if (pending !== 2'd0) begin
         errors++;
         $display("FAIL drain_pending: pending=%0d expected 0", pending);
      end
   endtask

   task automatic test_limits_reset();
      rx_expect = 1'b1;
      step();
      step();
      step();
      checks++;
      if ({pending, expect_overflow} !== {2'd3, 1'b0}) begin
         errors++;
         $display("FAIL limit_full: pending=%0d ovf=%b expected 3 0", pending, expect_overflow);
      end
      step();
      rx_expect = 1'b0;
      checks++;
      if ({pending, expect_overflow} !== {2'd3, 1'b1}) begin
         errors++;
         $display("FAIL limit_overflow: pending=%0d ovf=%b expected 3 1", pending, expect_overflow);
      end
      rx_pins = 2'b01;
      step();
      rx_pins = 2'b01;
      step();
      rx_pins = 2'b10;
      step();
      rx_pins = 2'b11;
      step();
      checks++;
      if (rx_data_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_data: rx_data_valid=%b expected 1", rx_data_valid);
      end
      reset = 1'b1;
      rx_pins = 2'b01;
      step();
      reset = 1'b0;
      checks++;
      if ({pending, rx_active, rx_started, rx_sbs, rx_sbs_valid, rx_data, rx_data_valid,
           rx_counter, rx_done, word_valid, word, word_half, rx_timeout, rx_overrun,
           expect_overflow} !== 36'h0) begin
         errors++;
         $display("FAIL reset_mid_frame: pending=%0d active=%b dv=%b cnt=%0d ovf=%b expected all 0",
                  pending, rx_active, rx_data_valid, rx_counter, expect_overflow);
      end
      for (int i = 0; i < 4; i++) begin
         rx_pins = (i % 2 == 0) ? 2'b11 : 2'b01;
         step();
         checks++;
         if ({rx_started, rx_active} !== 2'b00) begin
            errors++;
            $display("FAIL residual%0d: started/active=%b%b expected 00", i, rx_started, rx_active);
         end
      end
      rx_pins = 2'b00;
      step();
   endtask

   initial begin
      test_reset();
      test_full_read();
      test_half_ack();
      test_no_pending();
      test_timeout();
      test_overrun();
      test_limits_reset();
      step();
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL words_missing: %0d expected words never appeared", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
